// File: rtl/std_fp_pkg.sv
// rtl/std_fp_pkg.sv - shared types and constants for the fixed-point pipes
//
// Purpose: state encoding for the MAC controller and the sub-multiplier
//          latency constant shared by RTL and scoreboards.
// Ports:   none (package).
package std_fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } fp_mac_state_e;

    // Cycles from sub-multiplier go to its done being visible.
    localparam int FP_MULT_LATENCY = 3;

endpackage

// File: rtl/std_fp_mult_pipe.sv
// rtl/std_fp_mult_pipe.sv - three-stage unsigned fixed-point multiplier
//
// Purpose: out = truncate((left * right) >> FRAC_WIDTH) to WIDTH bits, i.e.
//          product bits [2*WIDTH-INT_WIDTH-1 : WIDTH-INT_WIDTH]. Integer bits
//          above the kept window are silently dropped.
// Ports:
//   clk   in  1      clock
//   go    in  1      start; must stay high until done
//   left  in  WIDTH  multiplicand
//   right in  WIDTH  multiplier
//   out   out WIDTH  truncated product, valid while done is high
//   done  out 1      high FP_MULT_LATENCY cycles after go rose
module std_fp_mult_pipe #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             done
);
    import std_fp_pkg::*;

    logic [WIDTH-1:0]           r_a;
    logic [WIDTH-1:0]           r_b;
    logic [WIDTH-1:0]           r_prod;
    logic [WIDTH-1:0]           r_out;
    logic [FP_MULT_LATENCY-1:0] r_go_sr;

    // Datapath and progress tracker are deliberately unreset: one cycle with
    // go low empties the tracker, and the owner guarantees such a cycle.
    always_ff @(posedge clk) begin
        r_a    <= left;
        r_b    <= right;
        r_prod <= WIDTH'(({{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b}) >> FRAC_WIDTH);
        r_out  <= r_prod;
        if (!go) begin
            r_go_sr <= '0;
        end else begin
            r_go_sr <= {r_go_sr[FP_MULT_LATENCY-2:0], 1'b1};
        end
    end

    assign out  = r_out;
    assign done = r_go_sr[FP_MULT_LATENCY-1];

endmodule

// File: rtl/std_fp_mac_pipe.sv
// rtl/std_fp_mac_pipe.sv - saturating fixed-point multiply-accumulate, go/done
//
// Purpose: acc = sat(acc + left*right), or acc = left*right when clear is
//          sampled with go. clear alone in IDLE zeroes acc and overflow.
// Ports:
//   clk      in  1      clock
//   reset    in  1      asynchronous active-high reset
//   go       in  1      start request, held until done
//   clear    in  1      restart accumulation (with go) / zero acc (alone)
//   left     in  WIDTH  multiplicand
//   right    in  WIDTH  multiplier
//   out      out WIDTH  accumulator snapshot, updated when an op completes
//   overflow out 1      sticky saturation flag
//   done     out 1      one-cycle completion pulse
module std_fp_mac_pipe #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             clear,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             done
);
    import std_fp_pkg::*;

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_width
        $error("std_fp_mac_pipe: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end

    fp_mac_state_e    r_state;
    fp_mac_state_e    w_next_state;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic             r_clr;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             w_mult_go;
    logic             w_mult_done;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH:0]   w_sum;

    // Sub-multiplier go follows the state, not the port, so a protocol
    // violation on go cannot stall an op already in MUL.
    std_fp_mult_pipe #(
        .WIDTH      (WIDTH),
        .INT_WIDTH  (INT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) mult (
        .clk   (clk),
        .go    (w_mult_go),
        .left  (r_left),
        .right (r_right),
        .out   (w_prod),
        .done  (w_mult_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mult_go    = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_next_state = MUL;
                end
            end
            MUL: begin
                w_mult_go = 1'b1;
                if (w_mult_done) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Carry out of the widened sum is the only overflow source.
    assign w_base = r_clr ? '0 : r_acc;
    assign w_sum  = {1'b0, w_base} + {1'b0, w_prod};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left  <= '0;
            r_right <= '0;
            r_clr   <= 1'b0;
            r_acc   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_left  <= left;
                        r_right <= right;
                        r_clr   <= clear;
                    end else if (clear) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                MUL: begin
                    if (w_mult_done) begin
                        if (w_sum[WIDTH]) begin
                            r_acc <= '1;
                            r_out <= '1;
                            r_ovf <= 1'b1;
                        end else begin
                            r_acc <= w_sum[WIDTH-1:0];
                            r_out <= w_sum[WIDTH-1:0];
                            // With clr the base is zero, so no carry is possible
                            // and the stale flag is simply dropped here.
                            if (r_clr) begin
                                r_ovf <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out      = r_out;
    assign overflow = r_ovf;

endmodule
